// File: rtl/msrv32_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package msrv32_fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch entries; clear wins over push.
module msrv32_fetch_fifo
   import msrv32_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; empty gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/msrv32_instr_fetch_unit.sv
// Fetch PC owner, imem req/ack initiator and fetch buffer feeding decode.
// Optional MSRV32_FETCH_MISALIGN_EXC_EN: misaligned redirect raises an exception pulse.
module msrv32_instr_fetch_unit
   import msrv32_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   output logic [31:0] ms_riscv32_mp_imaddr_out,
   output logic        ms_riscv32_mp_imreq_out,
   input  logic        ms_riscv32_mp_imack_in,
   input  logic [31:0] ms_riscv32_mp_instr_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic        stall_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid_out,
   output logic        flush_out,
   output logic        misaligned_exc_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drain_addr_q, drain_addr_d;
   logic          redirect_q;
   logic [31:0]   target;
   logic          ack_hit, push, pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  push_entry, head;

   assign push_entry = '{pc: fetch_pc_q, instr: ms_riscv32_mp_instr_in};

   msrv32_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (ms_riscv32_mp_clk_in),
      .rst_n (ms_riscv32_mp_rst_n_in),
      .clear (branch_taken_in),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef MSRV32_FETCH_MISALIGN_EXC_EN
   logic exc_q, exc_d;
   assign misaligned_exc_out = exc_q;
`else
   logic unused_tgt_lo;
   assign unused_tgt_lo      = ^branch_target_in[1:0];
   assign misaligned_exc_out = 1'b0;
`endif

   always_comb begin
      target = {branch_target_in[31:2], 2'b00};
`ifdef MSRV32_FETCH_MISALIGN_EXC_EN
      exc_d = branch_taken_in && (branch_target_in[1:0] != 2'b00);
      if (exc_d) target = RESET_PC;
`endif
   end

   // Request side: DRAIN keeps presenting the squashed request until memory takes it.
   always_comb begin
      ms_riscv32_mp_imreq_out  = 1'b0;
      ms_riscv32_mp_imaddr_out = fetch_pc_q;
      case (state_q)
         FETCH: ms_riscv32_mp_imreq_out = (fifo_count < CW'(FIFO_DEPTH));
         DRAIN: begin
            ms_riscv32_mp_imreq_out  = 1'b1;
            ms_riscv32_mp_imaddr_out = drain_addr_q;
         end
         default: ;
      endcase
   end

   assign ack_hit = ms_riscv32_mp_imreq_out && ms_riscv32_mp_imack_in;
   assign push    = (state_q == FETCH) && ack_hit && !branch_taken_in && !fifo_full;

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (branch_taken_in) fetch_pc_d = target;
         end
         FETCH: begin
            if (branch_taken_in) begin
               fetch_pc_d = target;
               if (ms_riscv32_mp_imreq_out && !ms_riscv32_mp_imack_in) begin
                  state_d      = DRAIN;
                  drain_addr_d = fetch_pc_q;
               end
            end else if (push) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         DRAIN: begin
            if (branch_taken_in) fetch_pc_d = target;
            if (ms_riscv32_mp_imack_in) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         redirect_q   <= 1'b0;
`ifdef MSRV32_FETCH_MISALIGN_EXC_EN
         exc_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         redirect_q   <= branch_taken_in;
`ifdef MSRV32_FETCH_MISALIGN_EXC_EN
         exc_q        <= exc_d;
`endif
      end
   end

   assign instr_valid_out = !fifo_empty && !redirect_q;
   assign flush_out       = !instr_valid_out;
   assign instr_out       = instr_valid_out ? head.instr : NOP;
   assign pc_out          = fifo_empty ? fetch_pc_q : head.pc;
   assign pop             = instr_valid_out && !stall_in && !branch_taken_in;

endmodule

// File: tb/tb_msrv32_instr_fetch_unit.sv
// Directed + random bench for the fetch unit against a transaction-level queue model.
module tb_msrv32_instr_fetch_unit;
   import msrv32_fetch_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imaddr;
   logic        imreq;
   logic        imack = 1'b0;
   logic [31:0] instr_in = '0;
   logic        br = 1'b0;
   logic [31:0] br_tgt = '0;
   logic        stall = 1'b0;
   logic [31:0] instr_out, pc_out;
   logic        valid, flush, exc;

   int total = 0;
   int bad   = 0;

   // Model: expected fetch stream, squashed request, one-cycle redirect/exception flags.
   logic [31:0] m_q [$];
   logic [31:0] m_pc, m_stale_addr;
   bit          m_stale, m_redir, m_exc;

   always #5 clk = ~clk;

   msrv32_instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .ms_riscv32_mp_clk_in     (clk),
      .ms_riscv32_mp_rst_n_in   (rst_n),
      .ms_riscv32_mp_imaddr_out (imaddr),
      .ms_riscv32_mp_imreq_out  (imreq),
      .ms_riscv32_mp_imack_in   (imack),
      .ms_riscv32_mp_instr_in   (instr_in),
      .branch_taken_in          (br),
      .branch_target_in         (br_tgt),
      .stall_in                 (stall),
      .instr_out                (instr_out),
      .pc_out                   (pc_out),
      .instr_valid_out          (valid),
      .flush_out                (flush),
      .misaligned_exc_out       (exc)
   );

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc = RPC; m_stale = 0; m_redir = 0; m_exc = 0; m_stale_addr = '0;
   endtask

   task automatic reset_chk();
      chk("rst_imreq", {31'd0, imreq}, 32'd0);
      chk("rst_imaddr", imaddr, RPC);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd1);
      chk("rst_instr", instr_out, NOP);
      chk("rst_pc", pc_out, RPC);
      chk("rst_exc", {31'd0, exc}, 32'd0);
   endtask

   task automatic step(input bit b, input logic [31:0] t, input bit st, input bit ack);
      bit v, rq;
      logic [31:0] te;
      @(posedge clk); #1;
      br = b; br_tgt = t; stall = st; imack = ack; instr_in = memw(imaddr);
      @(negedge clk);
      v = (m_q.size() != 0) && !m_redir;
      chk("valid", {31'd0, valid}, {31'd0, v});
      chk("flush", {31'd0, flush}, {31'd0, !v});
      if (v) begin
         chk("pc_out", pc_out, m_q[0]);
         chk("instr_out", instr_out, memw(m_q[0]));
      end else begin
         chk("instr_nop", instr_out, NOP);
      end
      rq = m_stale ? 1'b1 : (m_q.size() < DEPTH);
      chk("imreq", {31'd0, imreq}, {31'd0, rq});
      if (rq) chk("imaddr", imaddr, m_stale ? m_stale_addr : m_pc);
      chk("exc", {31'd0, exc}, {31'd0, m_exc});
      if (b) begin
         te = {t[31:2], 2'b00};
         m_exc = 0;
`ifdef MSRV32_FETCH_MISALIGN_EXC_EN
         if (t[1:0] != 2'b00) begin te = RPC; m_exc = 1; end
`endif
         if (m_stale) begin
            if (ack) m_stale = 0;
         end else if (rq && !ack) begin
            m_stale = 1; m_stale_addr = m_pc;
         end
         m_q.delete();
         m_pc = te;
         m_redir = 1;
      end else begin
         m_redir = 0; m_exc = 0;
         if (v && !st) void'(m_q.pop_front());
         if (rq && ack) begin
            if (m_stale) m_stale = 0;
            else begin m_q.push_back(m_pc); m_pc = m_pc + 32'd4; end
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_chk();
      rst_n = 1'b1;
      // zero-wait memory, then stall to fill, then resume
      repeat (4) step(0, '0, 0, 1);
      repeat (4) step(0, '0, 1, 1);
      repeat (4) step(0, '0, 0, 1);
      // slow memory: three wait cycles per word
      repeat (2) begin
         repeat (3) step(0, '0, 0, 0);
         step(0, '0, 0, 1);
      end
      // redirect while a request is pending unacked
      step(0, '0, 0, 0);
      step(1, 32'h0000_0100, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 1);
      repeat (4) step(0, '0, 0, 1);
      // redirect coincident with ack
      step(1, 32'h0000_0200, 0, 1);
      repeat (4) step(0, '0, 0, 1);
      // redirect during drain retargets
      step(0, '0, 0, 0);
      step(1, 32'h0000_0300, 0, 0);
      step(1, 32'h0000_0340, 0, 0);
      step(0, '0, 0, 1);
      repeat (3) step(0, '0, 0, 1);
      // misaligned target
      step(1, 32'h0000_0102, 0, 1);
      repeat (4) step(0, '0, 0, 1);
      // address wrap
      step(1, 32'hFFFF_FFF8, 0, 1);
      repeat (5) step(0, '0, 0, 1);
      // reset with a request outstanding
      step(0, '0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b0; imack = 1'b0; br = 1'b0; stall = 1'b0;
      #1;
      model_reset();
      reset_chk();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step(0, '0, 0, 1);
      // random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom % 12) == 0, $urandom, ($urandom % 3) == 0, ($urandom % 3) != 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
